// File: rtl/twiddle_pkg.sv
// ---------------------------------------------------------------------------
// twiddle_pkg
// Shared width helpers and constants for the pipelined complex twiddle
// multiplier. All helpers are constant functions so they can size
// localparams inside parameterised modules.
//   prod_w      : width of one sign-extended partial product (DW+TW+2)
//   sum_w       : width of the Re/Im sum before rounding (prod_w+1)
//   round_w     : width used for the rounding addition (sum_w+1)
//   round_const : half-LSB added before the arithmetic shift by FRAC
//   sat_max/min : two's-complement limits of a DW-bit result
// ---------------------------------------------------------------------------
package twiddle_pkg;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

    function automatic int sum_w(input int dw, input int tw);
        return prod_w(dw, tw) + 1;
    endfunction

    function automatic int round_w(input int dw, input int tw);
        return sum_w(dw, tw) + 1;
    endfunction

    // A zero-fraction configuration needs no rounding offset.
    function automatic longint round_const(input int frac);
        return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    endfunction

    function automatic longint sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/signed_mult_reg.sv
// ---------------------------------------------------------------------------
// signed_mult_reg
// One-cycle registered signed multiplier: p <= a * b when en is high.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears p
//   en    : load enable (pipeline advance)
//   a     : AW-bit signed operand
//   b     : BW-bit signed operand
//   p     : AW+BW-bit signed registered product
// ---------------------------------------------------------------------------
module signed_mult_reg #(
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [AW-1:0]     a,
    input  logic signed [BW-1:0]     b,
    output logic signed [AW+BW-1:0]  p
);

    localparam int PW = AW + BW;

    // Operands are widened to the full product width first so the multiply
    // is carried out at PW bits with no context-dependent sizing.
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    assign a_ext = {{BW{a[AW-1]}}, a};
    assign b_ext = {{AW{b[BW-1]}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// ---------------------------------------------------------------------------
// twiddle_mult_pipe
// Fully pipelined complex twiddle multiplier (x + jy) * W using the
// three-multiplier form with precomputed c, c+s and c-s. Three register
// stages, valid/ready handshake with a single global stage enable,
// per-sample conjugate mode, round-half-up and optional saturation.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   i_valid      : input sample valid
//   o_ready_in   : block can accept (transfer on i_valid & o_ready_in)
//   i_x, i_y     : DW-bit signed real / imaginary data
//   i_c          : TW-bit signed cos term, Q(FRAC)
//   i_c_plus_s   : TW+1-bit signed c+s
//   i_c_minus_s  : TW+1-bit signed c-s
//   i_conj       : 1 = multiply by conj(W), sampled with the data
//   o_valid      : output valid
//   i_ready      : downstream accepts (transfer on o_valid & i_ready)
//   o_re, o_im   : DW-bit signed results
//   o_ovf        : a result was clamped (qualified by o_valid)
// ---------------------------------------------------------------------------
module twiddle_mult_pipe
    import twiddle_pkg::*;
#(
    parameter int DW   = 8,
    parameter int TW   = 8,
    parameter int FRAC = TW - 1,
    parameter int SAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready_in,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_y,
    input  logic signed [TW-1:0] i_c,
    input  logic signed [TW:0]   i_c_plus_s,
    input  logic signed [TW:0]   i_c_minus_s,
    input  logic                 i_conj,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im,
    output logic                 o_ovf
);

    // Raw product width of each multiplier: DW x (TW+1) and TW x (DW+1)
    // both give DW+TW+1 bits.
    localparam int MW = DW + TW + 1;
    localparam int PW = prod_w(DW, TW);
    localparam int WS = sum_w(DW, TW);
    localparam int WR = round_w(DW, TW);

    localparam logic signed [WR-1:0] RND     = WR'(round_const(FRAC));
    localparam logic signed [WR-1:0] SAT_MAX = WR'(sat_max(DW));
    localparam logic signed [WR-1:0] SAT_MIN = WR'(sat_min(DW));

    // ------------------------------------------------------------------
    // Global stage enable: the whole pipe moves together, and only stalls
    // when the output register holds a sample nobody has taken yet.
    // ------------------------------------------------------------------
    logic en;
    logic v1;
    logic v2;
    logic v3;

    assign en         = i_ready | ~v3;
    assign o_ready_in = en;
    assign o_valid    = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v1 <= i_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // ------------------------------------------------------------------
    // S1: register operands, the DW+1-bit difference and the coefficient
    // pair selected by the conjugate flag.
    // ------------------------------------------------------------------
    logic signed [DW:0]   d_in;
    logic signed [TW:0]   cy_mux;
    logic signed [TW:0]   cx_mux;

    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;
    logic signed [TW-1:0] c1;
    logic signed [DW:0]   d1;
    logic signed [TW:0]   cy1;
    logic signed [TW:0]   cx1;

    // d is one bit wider than the data so x - y can never wrap.
    assign d_in   = {i_x[DW-1], i_x} - {i_y[DW-1], i_y};
    assign cy_mux = i_conj ? i_c_plus_s  : i_c_minus_s;
    assign cx_mux = i_conj ? i_c_minus_s : i_c_plus_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1  <= '0;
            y1  <= '0;
            c1  <= '0;
            d1  <= '0;
            cy1 <= '0;
            cx1 <= '0;
        end else if (en) begin
            x1  <= i_x;
            y1  <= i_y;
            c1  <= i_c;
            d1  <= d_in;
            cy1 <= cy_mux;
            cx1 <= cx_mux;
        end
    end

    // ------------------------------------------------------------------
    // S2: three registered signed products.
    // ------------------------------------------------------------------
    logic signed [MW-1:0] p_r;
    logic signed [MW-1:0] p_i;
    logic signed [MW-1:0] p_z;

    signed_mult_reg #(.AW(DW), .BW(TW + 1)) u_mult_r (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (y1),
        .b     (cy1),
        .p     (p_r)
    );

    signed_mult_reg #(.AW(DW), .BW(TW + 1)) u_mult_i (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (x1),
        .b     (cx1),
        .p     (p_i)
    );

    signed_mult_reg #(.AW(TW), .BW(DW + 1)) u_mult_z (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (c1),
        .b     (d1),
        .p     (p_z)
    );

    // ------------------------------------------------------------------
    // S3: combine, round half-up, saturate or wrap, register the result.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] p_r_ext;
    logic signed [PW-1:0] p_i_ext;
    logic signed [PW-1:0] p_z_ext;
    logic signed [WS-1:0] re_sum;
    logic signed [WS-1:0] im_sum;
    logic signed [WR-1:0] re_rnd;
    logic signed [WR-1:0] im_rnd;
    logic signed [DW-1:0] re_fit;
    logic signed [DW-1:0] im_fit;
    logic                 re_clamp;
    logic                 im_clamp;

    assign p_r_ext = {{(PW - MW){p_r[MW-1]}}, p_r};
    assign p_i_ext = {{(PW - MW){p_i[MW-1]}}, p_i};
    assign p_z_ext = {{(PW - MW){p_z[MW-1]}}, p_z};

    assign re_sum = {p_r_ext[PW-1], p_r_ext} + {p_z_ext[PW-1], p_z_ext};
    assign im_sum = {p_i_ext[PW-1], p_i_ext} - {p_z_ext[PW-1], p_z_ext};

    // Rounding is done one bit wider than the sum so the half-LSB offset
    // cannot overflow; >>> on a signed operand floors toward -inf.
    assign re_rnd = ($signed({re_sum[WS-1], re_sum}) + RND) >>> FRAC;
    assign im_rnd = ($signed({im_sum[WS-1], im_sum}) + RND) >>> FRAC;

    // Returns {clamped, value}.
    function automatic logic [DW:0] fit(input logic signed [WR-1:0] v);
        logic [DW:0] r;
        if (SAT == 0) begin
            r = {1'b0, v[DW-1:0]};
        end else if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DW-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DW-1:0]};
        end else begin
            r = {1'b0, v[DW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        {re_clamp, re_fit} = fit(re_rnd);
        {im_clamp, im_fit} = fit(im_rnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_re  <= '0;
            o_im  <= '0;
            o_ovf <= 1'b0;
        end else if (en) begin
            o_re  <= re_fit;
            o_im  <= im_fit;
            o_ovf <= re_clamp | im_clamp;
        end
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_twiddle_mult_pipe
// Self-checking bench for twiddle_mult_pipe (DW=TW=8, FRAC=7). A saturating
// instance is fully checked against an integer reference model through an
// in-order scoreboard; a wrapping instance (SAT=0) shares the input stream
// for the W = -1 corner.
// ---------------------------------------------------------------------------
module tb_twiddle_mult_pipe;

    localparam int DW   = 8;
    localparam int TW   = 8;
    localparam int FRAC = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 i_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic                 i_conj  = 1'b0;
    logic signed [DW-1:0] i_x     = '0;
    logic signed [DW-1:0] i_y     = '0;
    logic signed [TW-1:0] i_c     = '0;
    logic signed [TW:0]   i_cps   = '0;
    logic signed [TW:0]   i_cms   = '0;

    logic                 o_ready_in;
    logic                 o_valid;
    logic                 o_ovf;
    logic signed [DW-1:0] o_re;
    logic signed [DW-1:0] o_im;

    logic                 w_ready_in;
    logic                 w_valid;
    logic                 w_ovf;
    logic signed [DW-1:0] w_re;
    logic signed [DW-1:0] w_im;

    twiddle_mult_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .SAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready_in  (o_ready_in),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_c         (i_c),
        .i_c_plus_s  (i_cps),
        .i_c_minus_s (i_cms),
        .i_conj      (i_conj),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_re        (o_re),
        .o_im        (o_im),
        .o_ovf       (o_ovf)
    );

    twiddle_mult_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .SAT(0)) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready_in  (w_ready_in),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_c         (i_c),
        .i_c_plus_s  (i_cps),
        .i_c_minus_s (i_cms),
        .i_conj      (i_conj),
        .o_valid     (w_valid),
        .i_ready     (1'b1),
        .o_re        (w_re),
        .o_im        (w_im),
        .o_ovf       (w_ovf)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: exact integer complex product, round half up,
    // then clamp (or wrap) to DW bits.
    // ------------------------------------------------------------------
    typedef struct {
        int re;
        int im;
        int ovf;
    } exp_t;

    function automatic void reduce(input longint v, input bit sat,
                                   output int r, output bit clamped);
        longint q;
        longint lim;
        lim = longint'(1) <<< (DW - 1);
        q = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        clamped = 1'b0;
        if (sat) begin
            if (q > lim - 1) begin q = lim - 1; clamped = 1'b1; end
            else if (q < -lim) begin q = -lim; clamped = 1'b1; end
        end else begin
            q = q & ((lim << 1) - 1);
            if (q >= lim) q = q - (lim << 1);
        end
        r = int'(q);
    endfunction

    function automatic exp_t model(input int x, input int y, input int c,
                                   input int cps, input int cms,
                                   input bit conj, input bit sat);
        exp_t   e;
        longint d, kre, kim, vre, vim;
        bit     cr, ci;
        d   = longint'(x) - longint'(y);
        kre = conj ? longint'(cps) : longint'(cms);
        kim = conj ? longint'(cms) : longint'(cps);
        vre = longint'(y) * kre + longint'(c) * d;
        vim = longint'(x) * kim - longint'(c) * d;
        reduce(vre, sat, e.re, cr);
        reduce(vim, sat, e.im, ci);
        e.ovf = int'(cr | ci);
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, between active edges.
    // ------------------------------------------------------------------
    exp_t                 sb[$];
    exp_t                 mon_e;
    int                   out_cnt    = 0;
    bit                   prev_stall = 1'b0;
    logic signed [DW-1:0] held_re;
    logic signed [DW-1:0] held_im;
    logic                 held_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check_eq("ready_rule", o_ready_in, !(o_valid && !i_ready));
            if (prev_stall) begin
                check_eq("stall_valid", o_valid, 1);
                check_eq("stall_re", o_re, held_re);
                check_eq("stall_im", o_im, held_im);
                check_eq("stall_ovf", o_ovf, held_ovf);
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", o_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_re", o_re, mon_e.re);
                    check_eq("sb_im", o_im, mon_e.im);
                    check_eq("sb_ovf", o_ovf, mon_e.ovf);
                    out_cnt++;
                end
            end
            if (i_valid && o_ready_in)
                sb.push_back(model(i_x, i_y, i_c, i_cps, i_cms, i_conj, 1'b1));
            prev_stall = o_valid && !i_ready;
            held_re    = o_re;
            held_im    = o_im;
            held_ovf   = o_ovf;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c,
                         input int cps, input int cms, input bit conj);
        i_valid = 1'b1;
        i_x     = DW'(x);
        i_y     = DW'(y);
        i_c     = TW'(c);
        i_cps   = (TW + 1)'(cps);
        i_cms   = (TW + 1)'(cms);
        i_conj  = conj;
    endtask

    task automatic drive_rand();
        drive(int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 511)) - 256,
              int'($urandom_range(0, 511)) - 256,
              1'($urandom_range(0, 1)));
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    bit tput_v[14];
    bit rst_v[6];
    int sent;
    int tries;
    int out_base;
    bit acc;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_re", o_re, 0);
        check_eq("rst_im", o_im, 0);
        check_eq("rst_ovf", o_ovf, 0);
        check_eq("rst_ready", o_ready_in, 1);
        #1 rst_n = 1'b1;
        tick();

        // Near-unity real input, W ~ 1
        drive(127, 0, 127, 127, 127, 1'b0);
        tick();
        idle();
        tick();
        check_eq("d1_early_valid", o_valid, 0);
        tick();
        check_eq("d1_valid", o_valid, 1);
        check_eq("d1_re", o_re, 126);
        check_eq("d1_im", o_im, 0);
        check_eq("d1_ovf", o_ovf, 0);
        repeat (2) tick();

        // Conjugate flag toggled back-to-back
        drive(0, 64, 0, 127, -127, 1'b0);
        tick();
        drive(0, 64, 0, 127, -127, 1'b1);
        tick();
        idle();
        tick();
        check_eq("d2a_valid", o_valid, 1);
        check_eq("d2a_re", o_re, -63);
        check_eq("d2a_im", o_im, 0);
        tick();
        check_eq("d2b_valid", o_valid, 1);
        check_eq("d2b_re", o_re, 64);
        check_eq("d2b_im", o_im, 0);
        check_eq("d2b_ovf", o_ovf, 0);
        repeat (2) tick();

        // W = -1 with most-negative data: clamp vs wrap
        drive(-128, -128, -128, -128, -128, 1'b0);
        tick();
        idle();
        repeat (2) tick();
        check_eq("d3_valid", o_valid, 1);
        check_eq("d3_re", o_re, 127);
        check_eq("d3_im", o_im, 127);
        check_eq("d3_ovf", o_ovf, 1);
        check_eq("d3w_valid", w_valid, 1);
        check_eq("d3w_re", w_re, -128);
        check_eq("d3w_im", w_im, -128);
        check_eq("d3w_ovf", w_ovf, 0);
        repeat (3) tick();

        // Full throughput: 10 back-to-back samples
        i_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (n < 10) drive_rand();
            else idle();
            tick();
            tput_v[n] = o_valid;
        end
        for (int n = 0; n < 14; n++)
            check_eq($sformatf("tput_valid_%0d", n), tput_v[n], (n >= 2 && n <= 11));
        repeat (2) tick();

        // Backpressure stream: 20 samples, random downstream ready
        out_base = out_cnt;
        sent  = 0;
        tries = 0;
        drive_rand();
        while (sent < 20 && tries < 500) begin
            i_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = o_ready_in;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 20) drive_rand();
                else idle();
            end
            tries++;
        end
        idle();
        check_eq("bp_sent", sent, 20);
        tries = 0;
        while ((sb.size() != 0 || o_valid) && tries < 200) begin
            i_ready = ($urandom_range(0, 1) != 0);
            tick();
            tries++;
        end
        check_eq("bp_drained", sb.size(), 0);
        check_eq("bp_out_count", out_cnt - out_base, 20);
        i_ready = 1'b1;
        repeat (2) tick();

        // Reset with samples in flight
        drive(127, 0, 127, 127, 127, 1'b0);
        tick();
        drive_rand();
        tick();
        drive_rand();
        tick();
        idle();
        check_eq("prerst_valid", o_valid, 1);
        check_eq("prerst_re", o_re, 126);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("arst_valid", o_valid, 0);
        check_eq("arst_re", o_re, 0);
        check_eq("arst_im", o_im, 0);
        check_eq("arst_ovf", o_ovf, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 64, 0, 127, -127, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            rst_v[k] = o_valid;
            if (k == 3) begin
                check_eq("postrst_re", o_re, 64);
                check_eq("postrst_im", o_im, 0);
            end
        end
        for (int k = 1; k <= 5; k++)
            check_eq($sformatf("postrst_valid_%0d", k), rst_v[k], (k == 3));
        repeat (2) tick();
        check_eq("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/twiddle_mult_pipe.md
Name: twiddle_mult_pipe

Overview:
Parametrised, fully pipelined complex twiddle multiplier for the FFT butterfly datapath, the successor to the fixed 8-bit twiddle multiplier. It computes (x + jy)·W using the 3-multiplier form with precomputed c, c+s and c−s. New in this generation:
- generic data and coefficient widths;
- valid/ready handshake with backpressure;
- a per-sample conjugate mode for the inverse FFT;
- round-half-up with saturation, plus an overflow flag.

Parameters:
DW, 8, signed data width of x, y and outputs (two's complement)
TW, 8, signed twiddle width of c; c+s and c−s are TW+1 bits
FRAC, TW-1, twiddle fractional bits; products are shifted right by FRAC
SAT, 1, 1 = saturate results to DW bits; 0 = wrap (truncate MSBs)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input sample valid
o_ready_in  out  1  block can accept; transfer when i_valid & o_ready_in
i_x  in  DW  real part of data, signed
i_y  in  DW  imaginary part of data, signed
i_c  in  TW  cos term, signed Q(FRAC)
i_c_plus_s  in  TW+1  c+s, signed
i_c_minus_s  in  TW+1  c−s, signed
i_conj  in  1  1 = multiply by conj(W) (IFFT); sampled with the data
o_valid  out  1  output valid
i_ready  in  1  downstream accepts; transfer when o_valid & i_ready
o_re  out  DW  real result
o_im  out  DW  imaginary result
o_ovf  out  1  1 if either o_re or o_im was clamped; qualified by o_valid

Behaviour:
- Arithmetic, normal mode (i_conj=0), with d = x−y (DW+1 bits):
  - Re = y·(c−s) + c·d
  - Im = x·(c+s) − c·d
- Conjugate mode (i_conj=1): swap the coefficient roles.
  - Re = y·(c+s) + c·d
  - Im = x·(c−s) − c·d
- Widths:
  - product: DW+TW+2 bits, sign-extended;
  - sum/difference: WS = DW+TW+3 bits.
  - Rounding: add 2^(FRAC−1) in WS+1 bits, then arithmetic shift right by FRAC.
  - SAT=1: clamp to [−2^(DW−1), 2^(DW−1)−1] and set o_ovf. SAT=0: keep the low DW bits and hold o_ovf at 0.
- Pipeline, 3 register stages, latency 3 cycles from accepted input to o_valid:
  - S1: register x, y, c, d, and the muxed coefficients (cy_coef, cx_coef) per i_conj.
  - S2: three registered signed products: P_r = y·cy_coef, P_i = x·cx_coef, P_z = c·d.
  - S3: Re = P_r + P_z and Im = P_i − P_z; round, saturate, then register o_re, o_im, o_ovf.
- Handshake:
  - Global stage enable en = i_ready | ~o_valid. All stages advance only when en = 1.
  - o_ready_in = en, combinational from i_ready and o_valid.
  - A bubble (i_valid = 0 while en = 1) propagates as valid = 0 through the stage valid bits v1, v2, v3 (v3 = o_valid).
  - Stall (o_valid & ~i_ready): every stage holds its data and valid. o_re, o_im and o_ovf must stay stable while o_valid is high and i_ready is low.
  - Full throughput: one sample per cycle when i_ready is held at 1.
- Reset (asynchronous assert, any time including mid-stream):
  - v1, v2, v3 = 0; o_re, o_im = 0; o_ovf = 0; all data registers = 0.
  - In-flight samples are discarded.
  - First acceptance is possible on the first clock edge after rst_n deasserts.
- Edge cases:
  - x = y = −2^(DW−1) gives d = 0 with no overflow, because d is DW+1 bits.
  - c = −2^(TW−1) (W = −1) can give a +1.0 result: it clamps to max with o_ovf = 1.
  - i_conj applies per sample; toggling it every cycle is legal.

Decomposition:
- Package twiddle_pkg:
  - width helper functions: prod_w(DW, TW) = DW+TW+2 and sum_w = prod_w+1;
  - round constant;
  - saturation limit constants as functions of DW.
- Sub-module signed_mult_reg: one-cycle registered signed multiplier with parameters AW and BW, inputs a, b and en, output p (AW+BW bits, reset to 0). Instantiated three times in S2.
- Round/saturate stays inline in S3.

Test Plan:
- x=127, y=0, c=127, c+s=127, c−s=127, conj=0 -> 3 cycles later o_re=126, o_im=0, o_ovf=0.
- x=0, y=64, c=0, c+s=127, c−s=−127: with conj=0 -> o_re=−63, o_im=0; with conj=1 on the next cycle -> o_re=64, o_im=0, o_ovf=0 (back-to-back, one cycle apart).
- x=−128, y=−128, c=−128, c+s=−128, c−s=−128 -> o_re=127, o_im=127, o_ovf=1. The same stimulus with SAT=0 -> o_re=−128, o_im=−128, o_ovf=0.
- Backpressure stream:
  - 20 random samples at i_valid=1, with i_ready toggled by a pseudo-random pattern.
  - Outputs must match the golden model in order, with no drop or duplicate.
  - Outputs must stay stable during stalls.
  - o_ready_in must be 0 exactly when o_valid=1 and i_ready=0.
- Throughput: i_ready=1 and 10 consecutive inputs -> 10 consecutive o_valid cycles starting at cycle 3.
- Reset mid-stream: assert rst_n=0 with two samples in flight -> o_valid drops to 0 immediately (asynchronously), and o_re=o_im=0. After release, a new sample appears 3 cycles later and stale samples never appear.
